// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: requests a word, waits for the response, presents it downstream.
// Define FETCH_MISALIGN_TRAP_EN to halt on a misaligned branch target instead of masking it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, HALT} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] redirect_pc;
  logic        redirect_trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_pc   = branch_target;
  assign redirect_trap = (branch_target[1:0] != 2'b00);
`else
  logic tgt_low_unused;
  assign tgt_low_unused = |branch_target[1:0];
  assign redirect_pc    = {branch_target[31:2], 2'b00};
  assign redirect_trap  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_ready) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = OUT;
        end
      end
      OUT: begin
        // Branch requests only matter on the cycle the instruction is consumed.
        if (!stall) begin
          if (branch_taken && redirect_trap) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            fetch_pc_d = branch_taken ? redirect_pc : (pc_q + 32'd4);
            state_d    = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == REQ);
  assign imem_addr    = fetch_pc_q;
  assign instr_valid  = (state_q == OUT);
  assign instr        = instr_q;
  assign op           = instr_q[6:0];
  assign funct3       = instr_q[14:12];
  assign funct7       = instr_q[31:25];
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: table-driven main sequence plus reset and
// misaligned-branch corner sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int nvec = 0;
  int nerr = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct3(funct3), .funct7(funct7),
    .pc(pc), .pc_plus4(pc_plus4), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        bt;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pp4;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [31:0] d, input logic s,
                     input logic b, input logic [31:0] t, input logic eq,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ep, input logic [31:0] ep4);
    vec_t x;
    x.ready = r; x.rvalid = v; x.rdata = d; x.stall = s; x.bt = b; x.tgt = t;
    x.req = eq; x.addr = ea; x.vld = ev; x.instr = ei; x.pc = ep; x.pp4 = ep4;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic s,
                      input logic b, input logic [31:0] t);
    @(negedge clk);
    imem_ready = r; imem_rvalid = v; imem_rdata = d;
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

    // Main sequence: fetch, stall, branch, wrap-around.
    add(0,0,32'h0,        0,0,32'h0,        1,32'h0,        0,32'h13,       32'h0,        32'h4);
    add(0,1,32'hDEADBEEF, 0,0,32'h0,        1,32'h0,        0,32'h13,       32'h0,        32'h4);
    add(1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,32'h13,       32'h0,        32'h4);
    add(0,1,32'h00500093, 0,0,32'h0,        0,32'h0,        1,32'h00500093, 32'h0,        32'h4);
    add(0,1,32'hBADBAD00, 1,1,32'h300,      0,32'h0,        1,32'h00500093, 32'h0,        32'h4);
    add(0,0,32'h0,        1,0,32'h0,        0,32'h0,        1,32'h00500093, 32'h0,        32'h4);
    add(0,0,32'h0,        1,0,32'h0,        0,32'h0,        1,32'h00500093, 32'h0,        32'h4);
    add(0,0,32'h0,        1,0,32'h0,        0,32'h0,        1,32'h00500093, 32'h0,        32'h4);
    add(0,0,32'h0,        0,0,32'h0,        1,32'h4,        0,32'h00500093, 32'h0,        32'h4);
    add(1,0,32'h0,        0,0,32'h0,        0,32'h4,        0,32'h00500093, 32'h0,        32'h4);
    add(0,0,32'h0,        0,0,32'h0,        0,32'h4,        0,32'h00500093, 32'h0,        32'h4);
    add(0,1,32'h40B50533, 0,0,32'h0,        0,32'h4,        1,32'h40B50533, 32'h4,        32'h8);
    add(0,0,32'h0,        0,1,32'h100,      1,32'h100,      0,32'h40B50533, 32'h4,        32'h8);
    add(1,0,32'h0,        0,1,32'h200,      0,32'h100,      0,32'h40B50533, 32'h4,        32'h8);
    add(0,1,32'h00B54533, 0,0,32'h0,        0,32'h100,      1,32'h00B54533, 32'h100,      32'h104);
    add(0,0,32'h0,        0,0,32'h0,        1,32'h104,      0,32'h00B54533, 32'h100,      32'h104);
    add(1,0,32'h0,        0,0,32'h0,        0,32'h104,      0,32'h00B54533, 32'h100,      32'h104);
    add(0,1,32'h00000013, 0,0,32'h0,        0,32'h104,      1,32'h00000013, 32'h104,      32'h108);
    add(0,0,32'h0,        0,1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 0,32'h00000013, 32'h104,      32'h108);
    add(1,0,32'h0,        0,0,32'h0,        0,32'hFFFFFFFC, 0,32'h00000013, 32'h104,      32'h108);
    add(0,1,32'h00100073, 0,0,32'h0,        0,32'hFFFFFFFC, 1,32'h00100073, 32'hFFFFFFFC, 32'h0);
    add(0,0,32'h0,        0,0,32'h0,        1,32'h0,        0,32'h00100073, 32'hFFFFFFFC, 32'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, imem_req},     32'h0);
    chk("rst_addr",  imem_addr,             32'h0);
    chk("rst_vld",   {31'b0, instr_valid},  32'h0);
    chk("rst_instr", instr,                 32'h13);
    chk("rst_op",    {25'b0, op},           32'h13);
    chk("rst_pc",    pc,                    32'h0);
    chk("rst_pp4",   pc_plus4,              32'h4);
    chk("rst_mis",   {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ready, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall, vecs[i].bt, vecs[i].tgt);
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].addr);
      chk($sformatf("v%0d_vld", i),   {31'b0, instr_valid}, {31'b0, vecs[i].vld});
      chk($sformatf("v%0d_instr", i), instr,                vecs[i].instr);
      chk($sformatf("v%0d_pc", i),    pc,                   vecs[i].pc);
      chk($sformatf("v%0d_pp4", i),   pc_plus4,             vecs[i].pp4);
      chk($sformatf("v%0d_mis", i),   {31'b0, misalign_err}, 32'h0);
      if (i == 3) chk("v3_op", {25'b0, op}, 32'h13);
      if (i == 11) begin
        chk("v11_op", {25'b0, op}, 32'h33);
        chk("v11_f3", {29'b0, funct3}, 32'h0);
        chk("v11_f7", {25'b0, funct7}, 32'h20);
      end
      if (i == 14) begin
        chk("v14_op", {25'b0, op}, 32'h33);
        chk("v14_f3", {29'b0, funct3}, 32'h4);
        chk("v14_f7", {25'b0, funct7}, 32'h0);
      end
    end

    // Reset pulsed while waiting for a response; the late response must be ignored.
    step(1, 0, 32'h0, 0, 0, 32'h0);
    chk("w_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_instr", instr,                32'h13);
    chk("arst_pc",    pc,                   32'h0);
    chk("arst_vld",   {31'b0, instr_valid}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("late_req",   {31'b0, imem_req},    32'h1);
    chk("late_addr",  imem_addr,            32'h0);
    chk("late_vld",   {31'b0, instr_valid}, 32'h0);
    chk("late_instr", instr,                32'h13);
    step(0, 1, 32'hDEADBEEF, 0, 0, 32'h0);
    chk("late2_req",   {31'b0, imem_req}, 32'h1);
    chk("late2_instr", instr,             32'h13);

    // Misaligned branch target on consume.
    step(1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 32'h00000013, 0, 0, 32'h0);
    chk("mb_vld", {31'b0, instr_valid}, 32'h1);
    step(0, 0, 32'h0, 0, 1, 32'h00000102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mb_mis", {31'b0, misalign_err}, 32'h1);
    chk("mb_req", {31'b0, imem_req},     32'h0);
    chk("mb_vld2", {31'b0, instr_valid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 32'h00000013, 0, 1, 32'h0);
      chk($sformatf("halt%0d_req", k), {31'b0, imem_req},     32'h0);
      chk($sformatf("halt%0d_vld", k), {31'b0, instr_valid},  32'h0);
      chk($sformatf("halt%0d_mis", k), {31'b0, misalign_err}, 32'h1);
    end
`else
    chk("mb_mis",  {31'b0, misalign_err}, 32'h0);
    chk("mb_req",  {31'b0, imem_req},     32'h1);
    chk("mb_addr", imem_addr,             32'h100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
